// File: rtl/timer_cmp_pkg.sv
// Shared types for the timer output-compare channel: output mode encoding
// and the default counter/compare width.
package timer_cmp_pkg;

  localparam int TIMER_CMP_WIDTH = 16;

  typedef enum logic [2:0] {
    OC_FROZEN   = 3'd0,
    OC_SET      = 3'd1,
    OC_CLEAR    = 3'd2,
    OC_TOGGLE   = 3'd3,
    OC_FORCE_LO = 3'd4,
    OC_FORCE_HI = 3'd5,
    OC_PWM1     = 3'd6,
    OC_PWM2     = 3'd7
  } oc_mode_e;

endpackage

// File: rtl/oc_ref_gen.sv
// Combinational next-value logic for the output-compare reference level.
// Event modes react only to hit; force and PWM modes re-evaluate every cycle.
module oc_ref_gen
  import timer_cmp_pkg::*;
#(
  parameter int WIDTH = TIMER_CMP_WIDTH
) (
  input  oc_mode_e         mode,
  input  logic             hit,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] cmp_active,
  input  logic             ref_cur,
  output logic             ref_nxt
);

  always_comb begin
    ref_nxt = ref_cur;
    case (mode)
      OC_FROZEN:   ref_nxt = ref_cur;
      OC_SET:      ref_nxt = hit ? 1'b1 : ref_cur;
      OC_CLEAR:    ref_nxt = hit ? 1'b0 : ref_cur;
      OC_TOGGLE:   ref_nxt = hit ? ~ref_cur : ref_cur;
      OC_FORCE_LO: ref_nxt = 1'b0;
      OC_FORCE_HI: ref_nxt = 1'b1;
      OC_PWM1:     ref_nxt = (count < cmp_active);
      OC_PWM2:     ref_nxt = (count >= cmp_active);
      default:     ref_nxt = ref_cur;
    endcase
  end

endmodule

// File: rtl/timer_compare_channel.sv
// Output-compare channel fed by the reload down-counter: double-buffered
// compare register, change-qualified match detection, waveform output and flags.
module timer_compare_channel
  import timer_cmp_pkg::*;
#(
  parameter int               WIDTH   = TIMER_CMP_WIDTH,
  parameter logic [WIDTH-1:0] RST_CMP = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             done,
  input  logic             cmp_wr,
  input  logic [WIDTH-1:0] cmp_wdata,
  input  logic             preload_en,
  input  logic [2:0]       mode,
  input  logic             out_pol,
  input  logic             flag_clr,
  output logic             oc_out,
  output logic             match_pulse,
  output logic             match_flag,
  output logic             ovr_flag,
  output logic [WIDTH-1:0] cmp_active
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] count_q;
  logic             ref_q;
  logic             ref_nxt;
  logic             hit;
  oc_mode_e         mode_e;

  assign mode_e = oc_mode_e'(mode);

  // A match is only the first cycle count shows the compare value, so a
  // counter stalled on the compare value does not retrigger.
  assign hit = (count != count_q) && (count == cmp_active);

  oc_ref_gen #(
    .WIDTH (WIDTH)
  ) u_ref_gen (
    .mode       (mode_e),
    .hit        (hit),
    .count      (count),
    .cmp_active (cmp_active),
    .ref_cur    (ref_q),
    .ref_nxt    (ref_nxt)
  );

  // Compare registers: shadow always captures writes; active register either
  // follows writes directly or takes the shadow on the reload event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow     <= RST_CMP;
      cmp_active <= RST_CMP;
    end else begin
      if (cmp_wr) begin
        shadow <= cmp_wdata;
      end
      if (!preload_en) begin
        if (cmp_wr) begin
          cmp_active <= cmp_wdata;
        end
      end else if (done) begin
        cmp_active <= cmp_wr ? cmp_wdata : shadow;
      end
    end
  end

  // Match stage: previous count, reference level and registered output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      ref_q       <= 1'b0;
      oc_out      <= 1'b0;
      match_pulse <= 1'b0;
    end else begin
      count_q     <= count;
      ref_q       <= ref_nxt;
      oc_out      <= ref_nxt ^ out_pol;
      match_pulse <= hit;
    end
  end

  // Sticky flags; a new hit takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_flag <= 1'b0;
      ovr_flag   <= 1'b0;
    end else begin
      if (hit) begin
        match_flag <= 1'b1;
      end else if (flag_clr) begin
        match_flag <= 1'b0;
      end
      if (hit && match_flag) begin
        ovr_flag <= 1'b1;
      end else if (flag_clr) begin
        ovr_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_compare_channel.sv
// Scoreboard bench for timer_compare_channel: the driver queues hand-computed
// per-cycle expectations, the monitor pops and compares them on falling edges.
module tb_timer_compare_channel;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] count;
  logic        done;
  logic        cmp_wr;
  logic [15:0] cmp_wdata;
  logic        preload_en;
  logic [2:0]  mode;
  logic        out_pol;
  logic        flag_clr;
  logic        oc_out;
  logic        match_pulse;
  logic        match_flag;
  logic        ovr_flag;
  logic [15:0] cmp_active;

  typedef struct {
    int          id;
    logic        oc;
    logic        mp;
    logic        mf;
    logic        ovr;
    logic [15:0] cmp;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  always #5 clk = ~clk;

  timer_compare_channel #(
    .WIDTH   (16),
    .RST_CMP (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .count       (count),
    .done        (done),
    .cmp_wr      (cmp_wr),
    .cmp_wdata   (cmp_wdata),
    .preload_en  (preload_en),
    .mode        (mode),
    .out_pol     (out_pol),
    .flag_clr    (flag_clr),
    .oc_out      (oc_out),
    .match_pulse (match_pulse),
    .match_flag  (match_flag),
    .ovr_flag    (ovr_flag),
    .cmp_active  (cmp_active)
  );

  function automatic void chk(input string nm, input int id, input logic [15:0] act,
                              input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", nm, id, act, req);
    end
  endfunction

  // Drive one cycle of inputs, then queue what the outputs must be after the edge.
  task automatic cyc(input logic [15:0] c, input logic d, input logic wr,
                     input logic [15:0] wd, input logic pre, input logic [2:0] m,
                     input logic pol, input logic clr,
                     input logic e_oc, input logic e_mp, input logic e_mf,
                     input logic e_ovr, input logic [15:0] e_cmp);
    exp_t e;
    count = c; done = d; cmp_wr = wr; cmp_wdata = wd;
    preload_en = pre; mode = m; out_pol = pol; flag_clr = clr;
    @(posedge clk);
    step_id++;
    e.id = step_id; e.oc = e_oc; e.mp = e_mp; e.mf = e_mf; e.ovr = e_ovr; e.cmp = e_cmp;
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("oc_out",      e.id, {15'd0, oc_out},      {15'd0, e.oc});
      chk("match_pulse", e.id, {15'd0, match_pulse}, {15'd0, e.mp});
      chk("match_flag",  e.id, {15'd0, match_flag},  {15'd0, e.mf});
      chk("ovr_flag",    e.id, {15'd0, ovr_flag},    {15'd0, e.ovr});
      chk("cmp_active",  e.id, cmp_active,           e.cmp);
    end
  end

  initial begin
    reset = 1'b1; count = '0; done = 1'b0; cmp_wr = 1'b0; cmp_wdata = '0;
    preload_en = 1'b0; mode = 3'd0; out_pol = 1'b0; flag_clr = 1'b0;
    #1 reset = 1'b0;
    #10;
    chk("rst_oc",  0, {15'd0, oc_out},      16'd0);
    chk("rst_mp",  0, {15'd0, match_pulse}, 16'd0);
    chk("rst_mf",  0, {15'd0, match_flag},  16'd0);
    chk("rst_ovr", 0, {15'd0, ovr_flag},    16'd0);
    chk("rst_cmp", 0, cmp_active,           16'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Toggle mode, count holds on compare value: one match only
    cyc(7, 0, 1, 5, 0, 3, 0, 0,  0, 0, 0, 0, 5);
    cyc(6, 0, 0, 0, 0, 3, 0, 0,  0, 0, 0, 0, 5);
    cyc(5, 0, 0, 0, 0, 3, 0, 0,  1, 1, 1, 0, 5);
    cyc(5, 0, 0, 0, 0, 3, 0, 0,  1, 0, 1, 0, 5);
    cyc(5, 0, 0, 0, 0, 3, 0, 0,  1, 0, 1, 0, 5);
    cyc(4, 0, 0, 0, 0, 3, 0, 0,  1, 0, 1, 0, 5);
    cyc(4, 0, 0, 0, 0, 3, 0, 1,  1, 0, 0, 0, 5);

    // Preload: write held in shadow until done; write+done forwards
    cyc(4, 0, 1, 10, 0, 0, 0, 0,  1, 0, 0, 0, 10);
    cyc(4, 0, 1,  3, 1, 0, 0, 0,  1, 0, 0, 0, 10);
    cyc(3, 0, 0,  0, 1, 0, 0, 0,  1, 0, 0, 0, 10);
    cyc(2, 1, 0,  0, 1, 0, 0, 0,  1, 0, 0, 0, 3);
    cyc(1, 1, 1,  7, 1, 0, 0, 0,  1, 0, 0, 0, 7);
    cyc(1, 0, 0,  0, 1, 0, 0, 0,  1, 0, 0, 0, 7);

    // PWM1 with compare 4, one period 9..0 then wrap
    cyc(9, 0, 1, 4, 0, 6, 0, 0,  0, 0, 0, 0, 4);
    for (int c = 8; c >= 0; c--)
      cyc(16'(c), 0, 0, 0, 0, 6, 0, 0,  c < 4, c == 4, c <= 4, 0, 4);
    cyc(9, 0, 0, 0, 0, 6, 0, 0,  0, 0, 1, 0, 4);
    // Inverted polarity; second hit without clear raises overcapture
    for (int c = 8; c >= 0; c--)
      cyc(16'(c), 0, 0, 0, 0, 6, 1, 0,  c >= 4, c == 4, 1, c <= 4, 4);

    // Clear coincident with a hit: set wins, then clear takes effect
    cyc(4, 0, 0, 0, 0, 6, 0, 1,  0, 1, 1, 1, 4);
    cyc(3, 0, 0, 0, 0, 6, 0, 1,  1, 0, 0, 0, 4);

    // Force high, then frozen holds the level through a hit, then force low
    cyc(3, 0, 0, 0, 0, 5, 0, 0,  1, 0, 0, 0, 4);
    cyc(2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4);
    cyc(4, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 4);
    cyc(5, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4);
    cyc(5, 0, 0, 0, 0, 4, 0, 0,  0, 0, 1, 0, 4);
    cyc(5, 0, 0, 0, 0, 4, 0, 1,  0, 0, 0, 0, 4);

    // PWM1 with compare 0: output never active; hit still occurs at count 0
    cyc(5, 0, 1, 0, 0, 6, 0, 0,  0, 0, 0, 0, 0);
    for (int c = 3; c >= 1; c--)
      cyc(16'(c), 0, 0, 0, 0, 6, 0, 0,  0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 6, 0, 0,  0, 1, 1, 0, 0);
    cyc(9, 0, 0, 0, 0, 6, 0, 0,  0, 0, 1, 0, 0);

    // SET, CLEAR, TOGGLE on wrap-to-zero hits
    cyc(0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 1, 1, 0);
    cyc(5, 0, 0, 0, 0, 2, 0, 0,  1, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 2, 0, 0,  0, 1, 1, 1, 0);
    cyc(5, 0, 0, 0, 0, 3, 0, 0,  0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 3, 0, 0,  1, 1, 1, 1, 0);

    // PWM2, then async reset while output and pulse are high
    cyc(3, 0, 1, 8, 0, 7, 0, 0,  1, 0, 1, 1, 8);
    cyc(9, 0, 0, 0, 0, 7, 0, 0,  1, 0, 1, 1, 8);
    cyc(8, 0, 0, 0, 0, 7, 0, 0,  1, 1, 1, 1, 8);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    #1 reset = 1'b0;
    #1;
    chk("async_oc",  99, {15'd0, oc_out},      16'd0);
    chk("async_mp",  99, {15'd0, match_pulse}, 16'd0);
    chk("async_mf",  99, {15'd0, match_flag},  16'd0);
    chk("async_ovr", 99, {15'd0, ovr_flag},    16'd0);
    chk("async_cmp", 99, cmp_active,           16'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_compare_channel.md
Name: timer_compare_channel

Overview:
- Output-compare channel sitting directly downstream of the reload down-counter.
- Consumes the counter value and its reload/done pulse, and compares the value against a double-buffered compare register.
- Drives a registered waveform output in one of 8 modes (set/clear/toggle/force/PWM), plus a sticky match flag and an overcapture flag for the interrupt logic.

Parameters:
- WIDTH, 16, width of counter value and compare register.
- RST_CMP, 0, reset value of shadow and active compare registers.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- count  in  WIDTH  current value from the down-counter.
- done  in  1  one-cycle reload pulse from the down-counter (update event).
- cmp_wr  in  1  write strobe for the shadow compare register.
- cmp_wdata  in  WIDTH  compare write data.
- preload_en  in  1  1 = active compare loads only on done; 0 = loads on write.
- mode  in  3  output mode (oc_mode_e).
- out_pol  in  1  1 = invert final output.
- flag_clr  in  1  clear match_flag and ovr_flag.
- oc_out  out  1  registered waveform output.
- match_pulse  out  1  one-cycle pulse per compare match.
- match_flag  out  1  sticky match flag.
- ovr_flag  out  1  sticky overcapture flag.
- cmp_active  out  WIDTH  currently active compare value.

Behaviour:
- Reset (reset low, async):
  - shadow and cmp_active = RST_CMP.
  - count_q = 0; internal reference ref = 0.
  - oc_out, match_pulse, match_flag, ovr_flag = 0.
- Shadow register: loads cmp_wdata on cmp_wr, next edge.
- Active register:
  - preload_en=0: cmp_active loads cmp_wdata on the cmp_wr edge (bypasses shadow).
  - preload_en=1: cmp_active loads shadow on a done edge.
  - cmp_wr and done in the same cycle with preload_en=1: cmp_active takes the new cmp_wdata (write forwards).
- Change detection:
  - count_q registers count every cycle.
  - hit = (count != count_q) && (count == cmp_active).
  - A count holding at the compare value across many cycles yields exactly one hit.
  - Reset release with count == cmp_active and count_q = 0 != count gives a hit. If count == 0 == cmp_active, no hit.
- match_pulse: registered hit; high for exactly the cycle after count first shows the matching value.
- Flags:
  - match_flag: set on hit, cleared by flag_clr. Simultaneous hit and flag_clr: set wins.
  - ovr_flag: set when hit occurs while match_flag is already 1, cleared by flag_clr. Same priority rule: set wins.
- ref update per mode, same edge as match_pulse:
  - 0 FROZEN: ref holds.
  - 1 SET: ref <= 1 on hit.
  - 2 CLEAR: ref <= 0 on hit.
  - 3 TOGGLE: ref <= ~ref on hit.
  - 4 FORCE_LO: ref <= 0 every cycle.
  - 5 FORCE_HI: ref <= 1 every cycle.
  - 6 PWM1: ref <= (count < cmp_active) every cycle.
  - 7 PWM2: ref <= (count >= cmp_active) every cycle.
- oc_out = ref ^ out_pol, driven from a flop (ref and pol combined before the register). Latency from count input to oc_out is 1 cycle.
- Mode change mid-operation: ref keeps its value until the new mode's first event or evaluation; no glitch, no reset of flags.
- Boundaries:
  - cmp_active = 0 in PWM1 gives constant inactive output.
  - cmp_active > any reachable count in PWM1 gives constant active output.
  - Wrap (count 0 to reload) behaves like any other value change; a hit occurs if reload == cmp_active.
- All arithmetic unsigned, WIDTH bits, no extension.

Decomposition:
- Package timer_cmp_pkg: typedef enum logic [2:0] oc_mode_e {OC_FROZEN, OC_SET, OC_CLEAR, OC_TOGGLE, OC_FORCE_LO, OC_FORCE_HI, OC_PWM1, OC_PWM2}; localparam for default WIDTH.
- One sub-module, oc_ref_gen: takes mode, hit, count, cmp_active and ref, and returns next ref (combinational). The top holds all registers.

Test Plan:
- Reset, preload_en=0, write cmp=5, mode=TOGGLE, count steps 7,6,5,5,5,4 -> single match_pulse the cycle after count=5 appears; oc_out 0->1 once; match_flag=1; ovr_flag=0.
- preload_en=1, cmp_active=10, write 3 mid-period -> cmp_active stays 10 until done pulse, then 3; cmp_wr and done in the same cycle with data 7 -> cmp_active=7.
- mode=PWM1, cmp=4, count cycles 9 down to 0 with reload 9 -> oc_out high for count 3..0 (4 of 10 values), 1-cycle delayed; out_pol=1 inverts the pattern.
- Two hits without flag_clr -> ovr_flag=1; flag_clr asserted in the same cycle as a third hit -> match_flag stays 1, ovr_flag stays 1.
- mode=FORCE_HI then switch to FROZEN -> oc_out stays 1; cmp=0 in PWM1 -> oc_out constant 0.
- Assert reset mid-PWM with oc_out=1 -> oc_out, flags, match_pulse go 0 immediately (async); cmp_active=RST_CMP.
